// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with terminal-count detection.
// Software controls (clear/load/start/pause) steer a four-state FSM; done pulses once per expiry.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             zero_flag,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [15:0]      r_pre;
  logic             r_done;

  logic w_count_nz;
  logic w_reload_nz;
  logic w_tick;
  logic w_expire;
  logic w_rearm;

  assign w_count_nz  = (r_count != '0);
  assign w_reload_nz = (r_reload != '0);
  // A pause request in RUN wins over the decrement of that same cycle.
  assign w_tick      = (r_state == S_RUN) && !pause && (r_pre == PRE_LAST);
  assign w_expire    = w_tick && (r_count == WIDTH'(1));
  assign w_rearm     = auto_reload && w_reload_nz;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear || load) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start && w_count_nz) w_next = S_RUN;
        S_RUN: begin
          if (pause)                     w_next = S_PAUSED;
          else if (w_expire && !w_rearm) w_next = S_DONE;
        end
        S_PAUSED: if (start) w_next = S_RUN;
        S_DONE:   if (start && w_reload_nz) w_next = S_RUN;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state == S_RUN) || (r_state == S_PAUSED);
    zero_flag = !w_count_nz;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count  <= '0;
      r_reload <= '0;
      r_pre    <= '0;
      r_done   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_pre   <= '0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_count  <= load_val;
      r_reload <= load_val;
      r_pre    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start && w_count_nz) r_pre <= '0;
        S_DONE: begin
          if (start && w_reload_nz) begin
            r_count <= r_reload;
            r_pre   <= '0;
          end
        end
        S_RUN: begin
          if (!pause) begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_expire) begin
              r_done  <= 1'b1;
              r_count <= w_rearm ? r_reload : '0;
            end else if (w_tick) begin
              r_count <= r_count - WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign count_out = r_count;
  assign done      = r_done;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, prescaled down-counter with terminal-count detection. It is the decrementing counterpart to the up-counter with rollover flag, and serves as the calculator's interval and timeout source, for example for key-repeat delay and display-blank timing. Software-visible controls (load/start/pause/clear) drive a four-state FSM. A single-cycle `done` pulse marks each expiry, with optional automatic reload.

## Interface
Parameters:
- WIDTH, 4, bit width of count and load value
- PRESCALE, 1, clock cycles per decrement while running (legal range 1..2^16−1)

Ports:
- clk  input  1  system clock, rising-edge
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear: count to 0, FSM to IDLE
- load  input  1  capture load_val into count and reload register
- load_val  input  WIDTH  value captured on load
- start  input  1  begin/resume counting
- pause  input  1  freeze counting while running
- auto_reload  input  1  on expiry, reload and keep running
- count_out  output  WIDTH  current count (registered)
- zero_flag  output  1  high when count_out == 0 (combinational from count register)
- done  output  1  one-cycle pulse on each expiry (registered)
- busy  output  1  high in RUN or PAUSED

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Internal regs: count, reload_reg (WIDTH), prescale counter (0..PRESCALE−1), state, done.
- Reset (n_rst low, async): state IDLE, count 0, reload_reg 0, prescaler 0, done 0. Outputs: count_out 0, zero_flag 1, done 0, busy 0.
- Control priority per edge: clear > load > start/pause > decrement.
- clear:
  - Sets count to 0, prescaler to 0, state to IDLE, done to 0.
  - reload_reg is kept.
- load, from any state:
  - Sets count and reload_reg to load_val, prescaler to 0, state to IDLE.
  - No done pulse.
- start:
  - IDLE with count ≠ 0: go to RUN, prescaler 0.
  - IDLE with count = 0: ignored.
  - PAUSED: go to RUN; prescaler resumes from its held value.
  - DONE: if reload_reg ≠ 0, load count from reload_reg and go to RUN; otherwise ignored.
  - RUN: ignored.
- pause:
  - RUN: go to PAUSED; count and prescaler hold.
  - Any other state: ignored.
  - start and pause asserted together: pause wins in RUN, start wins in PAUSED.
- RUN decrement:
  - The prescaler increments every cycle and wraps at PRESCALE−1.
  - The wrap cycle is a tick; on a tick, count decrements by 1.
- Expiry occurs on a tick with count == 1:
  - auto_reload = 1 and reload_reg ≠ 0: count loads reload_reg, done pulses, state stays RUN.
  - Otherwise: count becomes 0, done pulses, state goes to DONE.
- Count never wraps below 0. No decrement occurs in IDLE, PAUSED or DONE.
- done is high exactly one cycle per expiry and is otherwise 0.

## Timing
- All outputs except zero_flag are registered. Effects of inputs sampled at edge k appear after edge k.
- With PRESCALE = 1, after start is sampled at edge k with count N:
  - count_out = N−i after edge k+i.
  - count_out reaches 0 (with done high) after edge k+N.
  - done deasserts after edge k+N+1.
- With general PRESCALE P: the first decrement occurs at edge k+P, and expiry at edge k+N·P.
- PAUSED cycles add exactly their duration to the expiry time; the prescaler phase is preserved.
- With auto_reload, the period is reload_reg·P cycles. Consecutive done pulses are separated by that many cycles.
- Reset asserted mid-RUN: outputs go to reset values immediately (async). Counting resumes only on a new load + start after release.

## Test plan
- Reset: assert n_rst low for 2 cycles, release → count_out 0, zero_flag 1, done 0, busy 0.
- Basic countdown (PRESCALE 1): load 5, start → count_out 4,3,2,1,0 on successive negedges; done high only in the cycle count_out = 0; then busy 0 and zero_flag 1.
- Pause/resume: load 9, start, after 3 cycles count_out = 6; pause 5 cycles → count_out stays 6, busy 1; start → count_out 5 next cycle, reaches 0 six cycles after resume.
- Auto-reload: auto_reload 1, load 3, start → sequence 2,1,3,2,1,3…; done pulses every 3 cycles; busy stays 1; dropping auto_reload → next expiry gives count_out 0 and DONE.
- Clear and load mid-run: load 7, start, run 2 cycles (count_out 5), then clear → count_out 0, busy 0. Assert start → stays IDLE. Load 4 mid-run → count_out 4, IDLE, no done.
- Prescaler (PRESCALE 4): load 2, start → count_out 1 after 4 cycles; reaches 0 with done after 8 cycles. DONE + start → reloads 2 and runs again.
